// File: rtl/rv32i_pkg.sv
// rv32i_pkg: types and constants shared by the fetch stage and the decode controller.
// Contents: fetch FSM state encoding, the canonical NOP word, the default reset PC,
//           and the RV32I major opcode values used by decode.
package rv32i_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: holds the PC, issues one instruction read at a time, and hands the
// returned word (plus opcode/func3 slices) to decode over valid/ready.
// Ports: clk/rst (sync active-high); imem_req_*/imem_addr/imem_resp_* to instruction
//        memory; redirect_* from branch/jump resolution; instr_*/opcode/func3 to decode;
//        fetch_fault flags a misaligned redirect target.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            fetch_fault
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            kill;  // the one outstanding response is stale and must be dropped

  logic accept;
  logic misaligned;
  logic outstanding;

  assign imem_req_valid = (state == REQ) && !rst;
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign misaligned     = (redirect_pc[1:0] != 2'b00);

  // A request is still in flight after this edge if one is accepted now, or one was
  // already pending and its response is not arriving this cycle.
  assign outstanding = accept
                    || ((state == WAIT) && !imem_resp_valid)
                    || ((state == FAULT) && kill && !imem_resp_valid);

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= REQ;
      pc          <= RESET_PC[XLEN-1:0];
      kill        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      fetch_fault <= 1'b0;
    end else if (redirect_valid && misaligned) begin
      // PC is left untouched; only an aligned redirect leaves FAULT.
      state       <= FAULT;
      fetch_fault <= 1'b1;
      instr_valid <= 1'b0;
      kill        <= outstanding;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      unique case (state)
        REQ: begin
          if (accept) begin
            kill  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            kill  <= 1'b0;
            state <= REQ;
          end else begin
            kill  <= 1'b1;
          end
        end
        HOLD: begin
          // A simultaneous instr_ready has already handed the word to decode.
          instr_valid <= 1'b0;
          state       <= REQ;
        end
        FAULT: begin
          fetch_fault <= 1'b0;
          if (kill && !imem_resp_valid) begin
            state <= WAIT;  // drain the stale response before fetching again
          end else begin
            kill  <= 1'b0;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (accept) state <= WAIT;
        end
        WAIT: begin
          if (imem_resp_valid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              instr       <= imem_resp_data;
              instr_pc    <= pc;
              pc          <= pc + XLEN'(4);
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= REQ;
          end
        end
        FAULT: begin
          if (imem_resp_valid) kill <= 1'b0;
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        fetch_fault;

  // second instance for the PC wrap check
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_instr_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic        w_fault;

  int n_assert = 0;
  int n_fail   = 0;
  bit auto_mem;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .func3(func3), .fetch_fault(fetch_fault)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc),
    .opcode(w_opcode), .func3(w_func3), .fetch_fault(w_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   mem_word = 32'h0050_0093;
      32'h4:   mem_word = 32'h00a0_0113;
      default: mem_word = {a[29:0], 2'b11};
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; with auto_mem set, a request accepted at this edge is answered
  // (zero-wait) during the next cycle. Inputs change and outputs are sampled at edge+1.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_resp_valid = acc;
      imem_resp_data  = mem_word(a);
    end
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1; auto_mem = 1'b1;
    w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = '0;
    tick(); tick();

    // reset state
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_nop", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_fault", fetch_fault, 0);
    rst = 1'b0;
    #1;

    // sequential fetch, zero-wait memory
    check("f0_req_valid", imem_req_valid, 1);
    check("f0_addr", imem_addr, 32'h0);
    tick();
    check("f0_wait_req_valid", imem_req_valid, 0);
    check("f0_wait_instr_valid", instr_valid, 0);
    tick();
    check("f0_instr_valid", instr_valid, 1);
    check("f0_instr", instr, 32'h0050_0093);
    check("f0_instr_pc", instr_pc, 32'h0);
    check("f0_opcode", opcode, 7'b0010011);
    check("f0_func3", func3, 3'b000);
    tick();
    check("f1_req_valid", imem_req_valid, 1);
    check("f1_addr", imem_addr, 32'h4);
    tick(); tick();
    check("f1_instr", instr, 32'h00a0_0113);
    check("f1_instr_pc", instr_pc, 32'h4);

    // decode stalls for five cycles
    instr_ready = 1'b0;
    held = instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_instr", instr, held);
      check("stall_instr_pc", instr_pc, 32'h4);
      check("stall_valid", instr_valid, 1);
      check("stall_no_req", imem_req_valid, 0);
    end
    instr_ready = 1'b1;
    tick();
    check("after_stall_req", imem_req_valid, 1);
    check("after_stall_addr", imem_addr, 32'h8);

    // redirect in WAIT, stale response two cycles later
    auto_mem = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    check("wait_redir_valid", instr_valid, 0);
    check("wait_redir_req", imem_req_valid, 1);
    check("wait_redir_addr", imem_addr, 32'h100);

    // redirect together with the response
    auto_mem = 1'b1;
    tick();
    check("resp_redir_resp_present", imem_resp_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("resp_redir_valid", instr_valid, 0);
    check("resp_redir_addr", imem_addr, 32'h40);
    check("resp_redir_req", imem_req_valid, 1);

    // redirect in the same cycle as the accept
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    check("acc_redir_no_req", imem_req_valid, 0);
    tick();
    check("acc_redir_valid", instr_valid, 0);
    check("acc_redir_req", imem_req_valid, 1);
    check("acc_redir_addr", imem_addr, 32'h80);

    // misaligned redirect while a request is accepted; stale response drains in FAULT
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("fault_set", fetch_fault, 1);
    check("fault_no_req", imem_req_valid, 0);
    check("fault_instr_valid", instr_valid, 0);
    tick(); tick();
    check("fault_held", fetch_fault, 1);
    check("fault_still_no_req", imem_req_valid, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("fault_clear", fetch_fault, 0);
    check("fault_exit_req", imem_req_valid, 1);
    check("fault_exit_addr", imem_addr, 32'h200);
    tick(); tick();
    check("post_fault_instr", instr, 32'h0000_0803);
    check("post_fault_pc", instr_pc, 32'h200);
    tick();
    check("post_fault_next_addr", imem_addr, 32'h204);

    // reset while WAIT; late response after reset is ignored
    auto_mem = 1'b0;
    tick();
    check("pre_rst_wait", imem_req_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    check("late_resp_valid", instr_valid, 0);
    check("late_resp_instr", instr, 32'h0000_0013);
    check("restart_req", imem_req_valid, 1);
    check("restart_addr", imem_addr, 32'h0);

    // PC wrap on the second instance
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_req_ready = 1'b1;
    tick();
    w_req_ready = 1'b0; w_resp_valid = 1'b1; w_resp_data = 32'h0000_0013;
    tick();
    w_resp_valid = 1'b0;
    check("wrap_instr_valid", w_instr_valid, 1);
    check("wrap_instr_pc", w_instr_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_req", w_req_valid, 1);
    check("wrap_addr1", w_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the opcode/func3 decode controller.
- Holds the PC and issues one 32-bit instruction read at a time to instruction memory over a valid/ready request and response interface.
- Registers the returned word and presents it to decode with a valid/ready handshake, including pre-sliced opcode and func3 fields.
- Handles PC redirects from branches/jumps, discards stale responses, and flags misaligned redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/data width; only 32 supported

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  XLEN  word-aligned read address (= pc)
imem_resp_valid  input  1  read data valid; exactly one response per accepted request, arriving 1+ cycles after acceptance
imem_resp_data  input  32  instruction word
redirect_valid  input  1  load new PC (branch/jump)
redirect_pc  input  XLEN  redirect target
instr_valid  output  1  instr holds a fetched instruction
instr_ready  input  1  decode consumes instr this cycle
instr  output  32  fetched instruction
instr_pc  output  XLEN  address of instr
opcode  output  7  instr[6:0], to controller
func3  output  3  instr[14:12], to controller
fetch_fault  output  1  misaligned redirect target pending

Behaviour:
- Reset (rst=1 at clock edge): pc=RESET_PC, state=REQ, kill=0, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, fetch_fault=0.
- imem_req_valid is forced 0 while rst=1; otherwise it is 1 only in REQ.
- Reset takes effect mid-transaction: any outstanding response arriving after reset is ignored because kill and state are cleared. Memory must also be reset with the core.
- At most one request outstanding. Internal kill flag marks that outstanding response as stale.

States:
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - Accept (req_valid & req_ready) -> WAIT.
  - Redirect in the same cycle as accept: pc<=redirect_pc, kill<=1.
  - Redirect without accept: pc<=redirect_pc, stay in REQ.
- WAIT:
  - resp_valid with kill=0 and no redirect: instr<=resp_data, instr_pc<=pc, pc<=pc+4 (wraps modulo 2^32), instr_valid<=1 -> HOLD.
  - resp_valid with kill=1: discard the response, kill<=0 -> REQ.
  - redirect without resp_valid: pc<=redirect_pc, kill<=1, stay in WAIT.
  - redirect together with resp_valid: discard the response, pc<=redirect_pc -> REQ.
- HOLD:
  - instr_ready: instr_valid<=0 -> REQ.
  - redirect: instr_valid<=0, pc<=redirect_pc -> REQ.
  - instr_ready and redirect in the same cycle: the handshake completes (decode has taken the instruction), then the redirect applies.
- FAULT:
  - Entered from any state when redirect_pc[1:0]!=0. Sets fetch_fault<=1, instr_valid<=0; kill<=1 if a request is outstanding.
  - No requests are issued.
  - resp_valid with kill=1 clears kill.
  - Aligned redirect: fetch_fault<=0, pc<=redirect_pc; -> WAIT if kill still set (drains), else -> REQ.
  - Misaligned redirect: stays in FAULT.
- Priority: rst > redirect > response/handshake.
- Latency: accept at cycle N, response at cycle N+1 -> instr_valid at N+2. With instr_ready tied high the next request is issued at N+3, giving a throughput of 1 instruction per 3 cycles with zero-wait memory.
- imem_addr[1:0] is always 0.
- instr, instr_pc, opcode and func3 remain stable while instr_valid=1 and instr_ready=0.

Decomposition:
- Shared package rv32i_pkg: fetch_state_t enum {REQ, WAIT, HOLD, FAULT}, NOP_INSTR=32'h0000_0013, RESET_PC_DEFAULT, RV32I opcode constants (OP_IMM=7'b0010011 etc.), shared with the controller.
- Single module; no sub-module. Field slicing is plain assigns.

Test Plan:
- Reset, zero-wait memory returning 32'h00500093 at 0x0 and 32'h00a00113 at 0x4, instr_ready=1 -> imem_addr 0x0 then 0x4; instr_valid with instr_pc=0x0, opcode=7'b0010011, func3=3'b000; second instruction instr_pc=0x4.
- instr_ready=0 for 5 cycles after instr_valid -> instr stable, imem_req_valid=0 throughout; ready=1 -> next request at pc+4 on the following cycle.
- Redirect to 0x100 while in WAIT, response 32'hDEADBEEF two cycles later -> response dropped, instr_valid stays 0, next imem_addr=0x100.
- Redirect to 0x40 in the same cycle as resp_valid -> response dropped, next request to 0x40. Redirect in the same cycle as request accept -> that request's response dropped.
- Redirect to 0x102 -> fetch_fault=1, no requests. Aligned redirect to 0x200 -> fetch_fault=0, request to 0x200.
- PC wrap: RESET_PC=32'hFFFF_FFFC -> first fetch at 0xFFFFFFFC, second at 0x0. Assert rst while in WAIT -> a late resp_valid is ignored and fetch restarts at RESET_PC.
